// File: rtl/power_accum.sv
// power_accum: multi-frame 4-lane power integrator with CLEAR/ACCUM/DUMP sequencing.
// Define POWER_ACCUM_SAT_EN to clamp accumulator additions instead of wrapping.
module power_accum #(
  parameter int NUM_COLS  = 64,
  parameter int IN_WIDTH  = 52,
  parameter int ACC_WIDTH = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   n_frames,
  input  logic                         frame_end,
  input  logic                         in_valid,
  input  logic [10:0]                  in_index_col1,
  input  logic [10:0]                  in_index_col2,
  input  logic [3:0][IN_WIDTH-1:0]     in_col1,
  input  logic [3:0][IN_WIDTH-1:0]     in_col2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [10:0]                  out_index,
  output logic [3:0][ACC_WIDTH-1:0]    out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int CW = $clog2(NUM_COLS);
`ifdef POWER_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef logic [ACC_WIDTH+1:0] wide_t;
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DUMP} state_t;
  state_t state;
  logic [3:0][ACC_WIDTH-1:0] mem [NUM_COLS];
  logic [3:0][ACC_WIDTH-1:0] sum1, sum2;
  logic [CW-1:0] ptr, adr1, adr2;
  logic [7:0] fcnt, nf;
  logic ok1, ok2, col2_on, use2, same, beat, drop;
  function automatic logic [ACC_WIDTH-1:0] fit(input wide_t s);
    fit = (SAT && |s[ACC_WIDTH+1:ACC_WIDTH]) ? '1 : s[ACC_WIDTH-1:0];
  endfunction
  assign adr1    = in_index_col1[CW-1:0];
  assign adr2    = in_index_col2[CW-1:0];
  assign ok1     = 32'(in_index_col1) < NUM_COLS;
  assign ok2     = 32'(in_index_col2) < NUM_COLS;
  assign col2_on = in_index_col1 > 11'd1;
  assign use2    = col2_on && ok2;
  assign same    = in_index_col1 == in_index_col2;
  assign beat    = state == ACCUM && in_valid;
  assign drop    = in_valid && (state != ACCUM || !ok1 || (col2_on && !ok2));
  assign busy    = state != IDLE;
  assign out_index = 11'(ptr);
  // Memory is frozen during DUMP, so the output can read it directly.
  assign out_data  = out_valid ? mem[ptr] : '0;
  always_comb begin
    sum1 = '0;
    sum2 = '0;
    for (int l = 0; l < 4; l++) begin
      sum1[l] = fit(wide_t'(mem[adr1][l]) + wide_t'(in_col1[l]) + ((use2 && same) ? wide_t'(in_col2[l]) : '0));
      sum2[l] = fit(wide_t'(mem[adr2][l]) + wide_t'(in_col2[l]));
    end
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[ptr] <= '0;
    else if (beat) begin
      if (use2 && !same) mem[adr2] <= sum2;
      if (ok1) mem[adr1] <= sum1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      fcnt      <= '0;
      nf        <= 8'd1;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= ((state == IDLE && start) ? 1'b0 : err) | drop;
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          ptr   <= '0;
          fcnt  <= '0;
          nf    <= (n_frames == 8'd0) ? 8'd1 : n_frames;
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == CW'(NUM_COLS - 1)) begin
            state <= ACCUM;
            fcnt  <= '0;
          end
        end
        ACCUM: if (frame_end) begin
          fcnt <= fcnt + 8'd1;
          if (fcnt + 8'd1 == nf) begin
            state     <= DUMP;
            out_valid <= 1'b1;
            ptr       <= '0;
          end
        end
        default: if (out_ready) begin
          if (ptr == CW'(NUM_COLS - 1)) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            done      <= 1'b1;
            ptr       <= '0;
          end else ptr <= ptr + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_power_accum.sv
// tb_power_accum: directed scoreboard bench for power_accum (default parameters).
module tb_power_accum;
  localparam int NC = 64, IW = 52, AW = 60;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, frame_end = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] n_frames = '0;
  logic [10:0] in_index_col1 = '0, in_index_col2 = '0;
  logic [3:0][IW-1:0] in_col1 = '0, in_col2 = '0;
  logic out_valid, busy, done, err;
  logic [10:0] out_index;
  logic [3:0][AW-1:0] out_data;
  typedef struct packed {logic [10:0] idx; logic [3:0][AW-1:0] d;} exp_t;
  exp_t q[$];
  logic [3:0][AW-1:0] emem [NC];
  logic [3:0][IW-1:0] zero_in = '0;
  int total = 0, bad = 0;
  power_accum #(.NUM_COLS(NC), .IN_WIDTH(IW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_frames(n_frames), .frame_end(frame_end),
    .in_valid(in_valid), .in_index_col1(in_index_col1), .in_index_col2(in_index_col2),
    .in_col1(in_col1), .in_col2(in_col2), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic logic [3:0][IW-1:0] ln(input longint a, b, c, d);
    ln = {IW'(d), IW'(c), IW'(b), IW'(a)};
  endfunction
  function automatic logic [3:0][AW-1:0] la(input longint a, b, c, d);
    la = {AW'(d), AW'(c), AW'(b), AW'(a)};
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input int i1, input logic [3:0][IW-1:0] c1, input int i2, input logic [3:0][IW-1:0] c2, input bit fe);
    in_valid = 1'b1;
    in_index_col1 = 11'(i1);
    in_index_col2 = 11'(i2);
    in_col1 = c1;
    in_col2 = c2;
    frame_end = fe;
    tick;
    in_valid = 1'b0;
    frame_end = 1'b0;
    in_col1 = '0;
    in_col2 = '0;
  endtask
  task automatic go(input int nf);
    start = 1'b1;
    n_frames = 8'(nf);
    tick;
    start = 1'b0;
    repeat (NC + 1) tick;
  endtask
  task automatic push_all;
    for (int c = 0; c < NC; c++) begin
      q.push_back({11'(c), emem[c]});
      emem[c] = '0;
    end
  endtask
  task automatic dump(input int stall);
    exp_t e;
    int g;
    bit s;
    push_all;
    g = 0;
    s = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && g < 300) begin
      if (out_valid) begin
        e = q[0];
        if (!s && stall >= 0 && out_index == 11'(stall)) begin
          s = 1'b1;
          out_ready = 1'b0;
          repeat (10) begin
            tick;
            chk("stall_hold", {out_index, out_data}, e);
          end
          out_ready = 1'b1;
        end
        chk("dump_col", {out_index, out_data}, e);
        void'(q.pop_front());
      end
      tick;
      g++;
    end
    chk("dump_drained", q.size(), 0);
    chk("done_pulse", done, 1);
    chk("valid_low_at_done", out_valid, 0);
    tick;
    chk("done_single", done, 0);
    chk("busy_after_done", busy, 0);
    q.delete();
    out_ready = 1'b0;
  endtask
  initial begin
    logic [IW-1:0] m;
    m = '1;
    for (int c = 0; c < NC; c++) emem[c] = '0;
    tick;
    tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick;
    go(1);
    chk("busy_accum", busy, 1);
    beat(5, ln(1, 2, 3, 4), 9, ln(10, 20, 30, 40), 1'b1);
    emem[5] = la(1, 2, 3, 4);
    emem[9] = la(10, 20, 30, 40);
    dump(-1);
    chk("err_clean", err, 0);
    go(3);
    for (int f = 0; f < 3; f++) begin
      beat(7, ln(100, 100, 100, 100), 0, zero_in, 1'b1);
      chk("busy_frames", busy, 1);
    end
    emem[7] = la(300, 300, 300, 300);
    dump(-1);
    go(1);
    beat(12, ln(5, 5, 5, 5), 12, ln(7, 7, 7, 7), 1'b0);
    beat(1, ln(2, 2, 2, 2), 20, ln(9, 9, 9, 9), 1'b1);
    emem[12] = la(12, 12, 12, 12);
    emem[1] = la(2, 2, 2, 2);
    dump(4);
    in_valid = 1'b1;
    in_index_col1 = 11'd3;
    in_col1 = ln(1, 1, 1, 1);
    tick;
    in_valid = 1'b0;
    in_col1 = '0;
    chk("err_idle_beat", err, 1);
    start = 1'b1;
    n_frames = 8'd0;
    tick;
    start = 1'b0;
    chk("err_cleared_by_start", err, 0);
    repeat (NC + 1) tick;
    beat(70, ln(9, 9, 9, 9), 30, zero_in, 1'b0);
    chk("err_idx1_range", err, 1);
    beat(2, ln(1, 1, 1, 1), 70, ln(4, 4, 4, 4), 1'b1);
    emem[2] = la(1, 1, 1, 1);
    dump(-1);
    chk("err_sticky", err, 1);
    go(2);
    chk("err_cleared_again", err, 0);
    repeat (128) beat(3, ln(m, m, m, m), 3, ln(m, m, m, m), 1'b0);
    beat(3, ln(254, 254, 254, 254), 0, zero_in, 1'b1);
    beat(3, ln(5, 5, 5, 5), 0, zero_in, 1'b1);
`ifdef POWER_ACCUM_SAT_EN
    emem[3] = '1;
`else
    emem[3] = la(3, 3, 3, 3);
`endif
    dump(-1);
    go(1);
    beat(5, ln(1, 1, 1, 1), 9, ln(2, 2, 2, 2), 1'b1);
    out_ready = 1'b1;
    repeat (3) tick;
    chk("mid_dump_index", out_index, 3);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_index", out_index, 0);
    chk("async_rst_data", out_data, 0);
    rst = 1'b0;
    out_ready = 1'b0;
    tick;
    chk("idle_after_rst", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
